psum_drain_ctrl: RTL

- Downstream neighbour of the partial-sum accumulator controller.
- After the last accumulation pass of a layer, it reads the packed psum words (NUM_KERNEL lanes × BIT_WIDTH) sequentially from psum memory and streams them out over a valid/ready interface.
- It writes zero back to each drained address, so memory is clean for the next layer's accumulation.
- Credit-limited issue plus a small output FIFO absorb memory read latency under backpressure.

---
 rtl/psum_drain_ctrl_pkg.sv | 24 ++
 rtl/psum_drain_fifo.sv | 57 +++++
 rtl/psum_drain_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/psum_drain_ctrl_pkg.sv
// Shared definitions for the psum drain controller and its accumulator neighbour.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psum_drain_ctrl_pkg;

    // Lane geometry shared with the partial-sum accumulator controller.
    localparam int PSUM_BIT_WIDTH  = 8;
    localparam int PSUM_NUM_KERNEL = 4;
    localparam int PSUM_DATA_WIDTH = PSUM_BIT_WIDTH * PSUM_NUM_KERNEL;

    // Drain sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // Bit offset of lane k inside a packed psum word.
    function automatic int lane_lsb(input int k, input int bw);
        return k * bw;
    endfunction

endpackage

// File: rtl/psum_drain_fifo.sv
// Generic synchronous FIFO with occupancy count, full and empty flags.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: caller must not push while full unless popping in the same cycle.
module psum_drain_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign head_dat = store[rd_ptr];

    // Storage array; no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains packed psum words from memory to a valid/ready stream, zeroing each address as it returns.
// Latency: start to first mem_rden 1 cycle; first out_vld MEM_DELAY+1 cycles after that; done 1 cycle after last transfer.
// Backpressure: reads issue only while inflight + FIFO occupancy < FIFO_DEPTH; out_vld never depends on out_rdy.
// Build option: define PSUM_DRAIN_RELU_EN to zero negative lanes at the output.
module psum_drain_ctrl
    import psum_drain_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH  = PSUM_BIT_WIDTH,
    parameter int NUM_KERNEL = PSUM_NUM_KERNEL,
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DELAY  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_radd,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    input  logic                  mem_oval,
    output logic [ADDR_WIDTH-1:0] mem_wadd,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_idat,
    output logic [DATA_WIDTH-1:0] out_dat,
    output logic                  out_vld,
    input  logic                  out_rdy
);
    localparam int IW = $clog2(MEM_DELAY + 2);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    drain_state_t          state;
    logic [ADDR_WIDTH-1:0] word_total;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] out_cnt;
    logic [IW-1:0]         inflight;
    logic [ADDR_WIDTH-1:0] addr_sr [MEM_DELAY];
    logic [DATA_WIDTH-1:0] head_dat;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  ret_vld;
    logic                  xfer;

    // Returns are only honoured for reads we issued, so a reset mid-drain ignores stragglers.
    assign ret_vld  = mem_oval && (inflight != '0);
    assign xfer     = out_vld && out_rdy;

    assign mem_rden = (state == ST_READ) && (rd_cnt < word_total) &&
                      ((int'(inflight) + int'(fifo_count)) < FIFO_DEPTH);
    assign mem_radd = rd_cnt;
    assign mem_wren = ret_vld;
    assign mem_wadd = addr_sr[MEM_DELAY-1];
    assign mem_idat = '0;
    assign out_vld  = !fifo_empty;

    // Outstanding read count; a simultaneous issue and return cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({mem_rden, ret_vld})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Carry each read address alongside the memory pipeline to drive the clear-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DELAY; i++) addr_sr[i] <= '0;
        end else begin
            addr_sr[0] <= mem_radd;
            for (int i = 1; i < MEM_DELAY; i++) addr_sr[i] <= addr_sr[i-1];
        end
    end

    psum_drain_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ret_vld),
        .push_dat (mem_odat),
        .pop      (xfer),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Per-lane output shaping; an empty FIFO presents all-zero data.
    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
        logic [BIT_WIDTH-1:0] lane;
        assign lane = head_dat[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH];
`ifdef PSUM_DRAIN_RELU_EN
        assign out_dat[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH] =
            (fifo_empty || lane[BIT_WIDTH-1]) ? '0 : lane;
`else
        assign out_dat[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH] = fifo_empty ? '0 : lane;
`endif
    end

    // Drain sequencer. An empty request falls through DRAIN so done keeps its registered timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            word_total <= '0;
            rd_cnt     <= '0;
            out_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (mem_rden) rd_cnt  <= rd_cnt + ADDR_WIDTH'(1);
            if (xfer)     out_cnt <= out_cnt + ADDR_WIDTH'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word_total <= num_words;
                        rd_cnt     <= '0;
                        out_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= (num_words == '0) ? ST_DRAIN : ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_cnt == word_total) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((out_cnt == word_total) ||
                        (xfer && (out_cnt + ADDR_WIDTH'(1) == word_total))) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Credits must make overflow and excess outstanding reads impossible.
    assert property (@(posedge clk) disable iff (rst) !(ret_vld && fifo_full && !xfer))
        else $error("psum_drain_ctrl: output FIFO overflow");
    assert property (@(posedge clk) disable iff (rst) int'(inflight) <= MEM_DELAY + 1)
        else $error("psum_drain_ctrl: too many reads in flight");

endmodule
